sum_accumulator: RTL and testbench

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

---
 rtl/sum_accumulator.sv | 86 ++++++++
 tb/tb_sum_accumulator.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// sum_accumulator: accumulates signed adder sums over a frame into a saturating
// accumulator, then holds the result (raw, 16-bit clamped, flags, beat count) until consumed.
module sum_accumulator #(
    parameter int IN_WIDTH  = 17,
    parameter int ACC_WIDTH = 24,
    parameter int OUT_WIDTH = 16,
    parameter int MAX_COUNT = 256,
    localparam int CW       = $clog2(MAX_COUNT) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_WIDTH-1:0]  in_sum,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] out_acc,
    output logic signed [OUT_WIDTH-1:0] out_sat,
    output logic                        out_clip,
    output logic                        out_ovf,
    output logic [CW-1:0]               out_count
);
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    localparam logic signed [ACC_WIDTH:0] AMAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] AMIN = {2'b11, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] OMAX = {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] OMIN = {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    state_t state, state_nxt;
    logic signed [ACC_WIDTH-1:0] acc, acc_nxt, ext;
    logic signed [ACC_WIDTH:0]   sum;
    logic [CW-1:0]               count, count_nxt, count_inc;
    logic                        ovf, ovf_nxt, fire, hi, lo;

    assign ext       = {{(ACC_WIDTH-IN_WIDTH){in_sum[IN_WIDTH-1]}}, in_sum};
    // one guard bit so the add can never wrap before the clamp decision
    assign sum       = {acc[ACC_WIDTH-1], acc} + {ext[ACC_WIDTH-1], ext};
    assign hi        = sum > AMAX;
    assign lo        = sum < AMIN;
    assign count_inc = count + CW'(1);
    assign in_ready  = state != HOLD;
    assign out_valid = state == HOLD;
    assign fire      = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        count_nxt = count;
        ovf_nxt   = ovf;
        if (state == IDLE && fire) begin
            acc_nxt   = ext;
            count_nxt = CW'(1);
            ovf_nxt   = 1'b0;
            state_nxt = in_last ? HOLD : ACC;
        end else if (state == ACC && fire) begin
            acc_nxt   = hi ? AMAX[ACC_WIDTH-1:0] : lo ? AMIN[ACC_WIDTH-1:0] : sum[ACC_WIDTH-1:0];
            ovf_nxt   = ovf || hi || lo;
            count_nxt = count_inc;
            state_nxt = (in_last || count_inc == CW'(MAX_COUNT)) ? HOLD : ACC;
        end else if (state == HOLD && out_ready) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            count <= count_nxt;
            ovf   <= ovf_nxt;
        end
    end

    assign out_acc   = acc;
    assign out_sat   = (acc > OMAX) ? OMAX[OUT_WIDTH-1:0] : (acc < OMIN) ? OMIN[OUT_WIDTH-1:0] : acc[OUT_WIDTH-1:0];
    assign out_clip  = (acc > OMAX) || (acc < OMIN);
    assign out_ovf   = ovf;
    assign out_count = count;
endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: directed vectors with hand-computed results, plus a
// random frame run against a saturating reference model.
module tb_sum_accumulator;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [16:0] in_sum = '0;
    logic               in_last = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [23:0] out_acc;
    logic signed [15:0] out_sat;
    logic               out_clip;
    logic               out_ovf;
    logic [8:0]         out_count;
    int                 errors = 0;
    int                 checks = 0;

    sum_accumulator dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_sat(out_sat), .out_clip(out_clip), .out_ovf(out_ovf),
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic beat(input int v, input bit last);
        in_valid = 1'b1;
        in_sum   = 17'(v);
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("pop_valid", out_valid, 0);
    endtask

    function automatic longint clamp(input longint v, input int w);
        longint mx = (64'sd1 <<< (w - 1)) - 1;
        longint mn = -(64'sd1 <<< (w - 1));
        return v > mx ? mx : v < mn ? mn : v;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_acc", out_acc, 0);
        check("rst_sat", out_sat, 0);
        check("rst_clip", out_clip, 0);
        check("rst_ovf", out_ovf, 0);
        check("rst_count", out_count, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        beat(100, 0); beat(-50, 0);
        check("f1_mid_valid", out_valid, 0);
        beat(30, 1);
        check("f1_valid", out_valid, 1);
        check("f1_acc", out_acc, 80);
        check("f1_sat", out_sat, 80);
        check("f1_count", out_count, 3);
        check("f1_clip", out_clip, 0);
        check("f1_ovf", out_ovf, 0);
        pop();

        beat(-65536, 1);
        check("f2_acc", out_acc, -65536);
        check("f2_sat", out_sat, -32768);
        check("f2_clip", out_clip, 1);
        check("f2_count", out_count, 1);
        check("f2_ovf", out_ovf, 0);
        pop();

        for (int i = 1; i <= 256; i++) begin
            beat(65535, 0);
            if (i == 128) begin
                check("f3_acc128", out_acc, 8388480);
                check("f3_ovf128", out_ovf, 0);
            end
            if (i == 129) begin
                check("f3_acc129", out_acc, 8388607);
                check("f3_ovf129", out_ovf, 1);
            end
            if (i == 255) check("f3_valid255", out_valid, 0);
        end
        check("f3_valid", out_valid, 1);
        check("f3_count", out_count, 256);
        check("f3_acc", out_acc, 8388607);
        check("f3_sat", out_sat, 32767);
        check("f3_ovf", out_ovf, 1);
        pop();

        beat(5, 1);
        check("f4_ovf_fresh", out_ovf, 0);
        in_valid = 1'b1; in_sum = 17'(9); in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("f4_hold_ready", in_ready, 0);
            check("f4_hold_valid", out_valid, 1);
            check("f4_hold_acc", out_acc, 5);
            check("f4_hold_count", out_count, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("f4_idle_valid", out_valid, 0);
        check("f4_idle_acc", out_acc, 5);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        check("f5_valid", out_valid, 1);
        check("f5_acc", out_acc, 9);
        check("f5_count", out_count, 1);
        pop();

        beat(1000, 0); beat(1000, 0); beat(1000, 0);
        check("f6_pre_acc", out_acc, 3000);
        #2 rst_n = 1'b0;
        #1;
        check("f6_rst_valid", out_valid, 0);
        check("f6_rst_acc", out_acc, 0);
        check("f6_rst_count", out_count, 0);
        @(posedge clk); #1;
        check("f6_rst_hold_valid", out_valid, 0);
        rst_n = 1'b1;
        beat(7, 1);
        check("f7_acc", out_acc, 7);
        check("f7_count", out_count, 1);
        pop();

        for (int f = 0; f < 10000; f++) begin
            int n = $urandom_range(1, 3);
            longint exp_acc = 0;
            bit exp_ovf = 0;
            for (int i = 0; i < n; i++) begin
                logic signed [16:0] r = 17'($urandom);
                longint s;
                while ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                end
                if (!in_ready) check("rnd_ready", in_ready, 1);
                beat(int'(r), i == n - 1);
                s = exp_acc + longint'(r);
                if (i == 0) exp_acc = longint'(r);
                else begin
                    if (clamp(s, 24) != s) exp_ovf = 1;
                    exp_acc = clamp(s, 24);
                end
            end
            check("rnd_valid", out_valid, 1);
            check("rnd_acc", out_acc, exp_acc);
            check("rnd_sat", out_sat, clamp(exp_acc, 16));
            check("rnd_count", out_count, n);
            check("rnd_ovf", out_ovf, exp_ovf);
            for (int k = 0; k < 50 && out_valid; k++) begin
                out_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            out_ready = 1'b0;
            if (out_valid) check("rnd_drain", out_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
